hand_sequencer: RTL and testbench
=================================

// Module: hand_sequencer
// PURPOSE
//  Scheduler that animates a 12-position clock hand on the VGA frame buffer.
//  It owns the line_drawer's start/done handshake and sequences each step:
//  erase the previous hand (colour 0), draw the new hand (colour 1), then hold
//  for a tick interval before advancing. It sits between the top level and
//  line_drawer and is the only block that drives line endpoints and pixel_color.
// PARAMETERS
//  NUM_STEPS    12          hand positions per revolution (table below)
//  TICK_CYCLES  50_000_000  clk cycles spent in HOLD per step (>=2)
//  CX           200         hand pivot x
//  CY           200         hand pivot y
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  reset        in   1   asynchronous, active-low reset
//  enable       in   1   1 = run animation; 0 = park after current line
//  draw_done    in   1   line_drawer finished current line (level or pulse)
//  draw_start   out  1   one-cycle pulse: latch endpoints, begin line
//  x0           out  10  line start x (always CX)
//  y0           out  9   line start y (always CY)
//  x1           out  10  line end x (endpoint table[step_sel])
//  y1           out  9   line end y
//  pixel_color  out  1   1 = draw, 0 = erase
//  step         out  4   current displayed hand index, 0..NUM_STEPS-1
//  busy         out  1   1 in ERASE_*/DRAW_* states
// BEHAVIOUR
//  Endpoint table (x1,y1), idx 0..11: (200,10)(295,35)(364,105)(390,200)
//   (364,295)(295,364)(200,390)(105,364)(35,295)(10,200)(35,105)(105,35).
//  Reset (reset=0, async): state=IDLE, step=0, prev_valid=0, tick_cnt=0,
//   draw_start=0, pixel_color=0, busy=0, x0=CX, y0=CY, x1/y1=table[0].
//  States: IDLE, ERASE_REQ, ERASE_WAIT, DRAW_REQ, DRAW_WAIT, HOLD.
//  IDLE: enable=1 -> prev_valid ? ERASE_REQ : DRAW_REQ. Else stay.
//  ERASE_REQ: step_sel=prev_step, pixel_color=0, draw_start=1 for exactly one
//   cycle -> ERASE_WAIT.
//  ERASE_WAIT: hold endpoints/colour; draw_done=1 -> DRAW_REQ.
//  DRAW_REQ: step_sel=step, pixel_color=1, draw_start pulse -> DRAW_WAIT.
//  DRAW_WAIT: draw_done=1 -> prev_step<=step, prev_valid<=1, tick_cnt<=0,
//   -> HOLD.
//  HOLD: enable=1: tick_cnt++; at tick_cnt==TICK_CYCLES-1 -> step<=step+1
//   (wraps NUM_STEPS-1 -> 0), -> ERASE_REQ. enable=0: tick_cnt frozen, stay.
//  x0,y0,x1,y1,pixel_color are registered and change only on the cycle
//   draw_start is asserted; constant throughout *_WAIT states.
//  draw_done ignored outside *_WAIT states; draw_done in the same cycle as
//   draw_start (REQ state) is ignored, so minimum line latency is 1 cycle.
//  enable deassert in ERASE/DRAW states: current erase+draw pair completes,
//   then parks in HOLD. Never abandons a started line.
//  step updates only on HOLD expiry; first revolution after reset skips erase.
//  Reset mid-line: immediate return to IDLE; pixels already written remain
//   (no erase of partial line).
//  tick_cnt width = $clog2(TICK_CYCLES); no overflow possible.
// TESTING (TICK_CYCLES=8, line_drawer model: done 5 cycles after start)
//  1 Reset release, enable=1 -> single draw_start with colour 1, x1=200,y1=10,
//    no erase pulse; step=0; HOLD lasts exactly 8 cycles.
//  2 Step 0->1 -> erase pulse (colour 0, 200,10) then draw pulse (colour 1,
//    295,35); step=1 after HOLD expiry; busy high through both lines only.
//  3 Run 12 steps -> step wraps 11->0; erase endpoint (105,35), draw (200,10).
//  4 enable=0 during DRAW_WAIT -> line completes, parks in HOLD, tick frozen;
//    re-enable -> remaining ticks counted, then next step.
//  5 Spurious draw_done in HOLD/IDLE/REQ -> no state change, no extra pulse.
//  6 reset low during ERASE_WAIT -> all outputs at reset values same cycle;
//    after release, first action is a draw (no erase) of table[0].

Source files
------------

// File: rtl/hand_sequencer_if.sv
// Line-drawer handshake bundle: endpoints, colour and the start/done pair
// that the sequencer owns on behalf of the line drawer.
interface hand_sequencer_if;
  logic       draw_start;
  logic       draw_done;
  logic [9:0] x0;
  logic [8:0] y0;
  logic [9:0] x1;
  logic [8:0] y1;
  logic       pixel_color;

  modport master (
    output draw_start, x0, y0, x1, y1, pixel_color,
    input  draw_done
  );

  modport slave (
    input  draw_start, x0, y0, x1, y1, pixel_color,
    output draw_done
  );
endinterface

// File: rtl/hand_sequencer.sv
// Animates a 12-position clock hand: erase previous hand, draw the new one,
// hold for a tick interval, advance. Drives the line drawer via the interface.
module hand_sequencer #(
  parameter int NUM_STEPS   = 12,
  parameter int TICK_CYCLES = 50_000_000,
  parameter int CX          = 200,
  parameter int CY          = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  hand_sequencer_if.master line,
  output logic [3:0]       step,
  output logic             busy
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE, ERASE_REQ, ERASE_WAIT, DRAW_REQ, DRAW_WAIT, HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    step_q, step_d;
  logic [3:0]    prev_step_q, prev_step_d;
  logic          prev_valid_q, prev_valid_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [9:0]    x1_q, x1_d;
  logic [8:0]    y1_q, y1_d;
  logic          color_q, color_d;

  function automatic logic [18:0] endpoint(input logic [3:0] idx);
    case (idx)
      4'd1:    endpoint = {10'd295, 9'd35};
      4'd2:    endpoint = {10'd364, 9'd105};
      4'd3:    endpoint = {10'd390, 9'd200};
      4'd4:    endpoint = {10'd364, 9'd295};
      4'd5:    endpoint = {10'd295, 9'd364};
      4'd6:    endpoint = {10'd200, 9'd390};
      4'd7:    endpoint = {10'd105, 9'd364};
      4'd8:    endpoint = {10'd35,  9'd295};
      4'd9:    endpoint = {10'd10,  9'd200};
      4'd10:   endpoint = {10'd35,  9'd105};
      4'd11:   endpoint = {10'd105, 9'd35};
      default: endpoint = {10'd200, 9'd10};
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      step_q       <= '0;
      prev_step_q  <= '0;
      prev_valid_q <= 1'b0;
      tick_q       <= '0;
      x1_q         <= 10'd200;
      y1_q         <= 9'd10;
      color_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      prev_step_q  <= prev_step_d;
      prev_valid_q <= prev_valid_d;
      tick_q       <= tick_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      color_q      <= color_d;
    end
  end

  // Endpoints/colour are loaded on the edge entering a REQ state, so they
  // first appear together with draw_start and stay put through the WAIT state.
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    prev_step_d  = prev_step_q;
    prev_valid_d = prev_valid_q;
    tick_d       = tick_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    color_d      = color_q;

    case (state_q)
      IDLE: begin
        if (enable) begin
          if (prev_valid_q) begin
            state_d      = ERASE_REQ;
            {x1_d, y1_d} = endpoint(prev_step_q);
            color_d      = 1'b0;
          end else begin
            state_d      = DRAW_REQ;
            {x1_d, y1_d} = endpoint(step_q);
            color_d      = 1'b1;
          end
        end
      end
      ERASE_REQ: state_d = ERASE_WAIT;
      ERASE_WAIT: begin
        if (line.draw_done) begin
          state_d      = DRAW_REQ;
          {x1_d, y1_d} = endpoint(step_q);
          color_d      = 1'b1;
        end
      end
      DRAW_REQ: state_d = DRAW_WAIT;
      DRAW_WAIT: begin
        if (line.draw_done) begin
          state_d      = HOLD;
          prev_step_d  = step_q;
          prev_valid_d = 1'b1;
          tick_d       = '0;
        end
      end
      HOLD: begin
        if (enable) begin
          if (tick_q == TW'(TICK_CYCLES - 1)) begin
            state_d      = ERASE_REQ;
            step_d       = (step_q == 4'(NUM_STEPS - 1)) ? 4'd0 : step_q + 4'd1;
            {x1_d, y1_d} = endpoint(prev_step_q);
            color_d      = 1'b0;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign line.draw_start  = (state_q == ERASE_REQ) || (state_q == DRAW_REQ);
  assign line.x0          = 10'(CX);
  assign line.y0          = 9'(CY);
  assign line.x1          = x1_q;
  assign line.y1          = y1_q;
  assign line.pixel_color = color_q;
  assign step             = step_q;
  assign busy             = (state_q == ERASE_REQ) || (state_q == ERASE_WAIT) ||
                            (state_q == DRAW_REQ)  || (state_q == DRAW_WAIT);

endmodule

// File: tb/tb_hand_sequencer.sv
// Scoreboard bench for hand_sequencer: expected lines are queued ahead of
// time and compared as each draw_start pulse appears.
module tb_hand_sequencer;
  localparam int TICK = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] step;
  logic       busy;

  int checks = 0;
  int errors = 0;

  hand_sequencer_if lineIf ();

  hand_sequencer #(
    .NUM_STEPS  (12),
    .TICK_CYCLES(TICK),
    .CX         (200),
    .CY         (200)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .line  (lineIf),
    .step  (step),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int tabX [12] = '{200, 295, 364, 390, 364, 295, 200, 105, 35, 10, 35, 105};
  int tabY [12] = '{10, 35, 105, 200, 295, 364, 390, 364, 295, 200, 105, 35};

  logic [19:0] expQ [$];
  logic [19:0] expLine;
  logic [19:0] gotLine;

  // Line drawer model: done is high for one cycle, five cycles after start.
  int   doneCnt = 0;
  logic modelDone = 1'b0;
  logic spurDone = 1'b0;
  assign lineIf.draw_done = modelDone | spurDone;

  always @(negedge clk) begin
    if (lineIf.draw_start) begin
      doneCnt   <= 5;
      modelDone <= 1'b0;
    end else if (doneCnt > 0) begin
      doneCnt   <= doneCnt - 1;
      modelDone <= (doneCnt == 1);
    end else begin
      modelDone <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (lineIf.draw_start) begin
      checks++;
      gotLine = {lineIf.pixel_color, lineIf.x1, lineIf.y1};
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_pulse: got colour/x1/y1 %h, no line expected", gotLine);
      end else begin
        expLine = expQ.pop_front();
        if (gotLine !== expLine || lineIf.x0 !== 10'd200 || lineIf.y0 !== 9'd200) begin
          errors++;
          $display("[TB] FAIL line_endpoint: got c/x1/y1=%h x0=%0d y0=%0d, need %h x0=200 y0=200",
                   gotLine, lineIf.x0, lineIf.y0, expLine);
        end
      end
    end
  end

  task automatic pushLine(input logic color, input int idx);
    expQ.push_back({color, 10'(tabX[idx]), 9'(tabY[idx])});
  endtask

  task automatic waitBusy(input logic lvl, output int cycles);
    cycles = -1;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      if (busy === lvl) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({lineIf.draw_start, lineIf.pixel_color, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: start/colour/busy=%b need 000",
               {lineIf.draw_start, lineIf.pixel_color, busy});
    end
    checks++;
    if (step !== 4'd0) begin
      errors++;
      $display("[TB] FAIL reset_step: got %0d need 0", step);
    end
    checks++;
    if (lineIf.x0 !== 10'd200 || lineIf.y0 !== 9'd200 || lineIf.x1 !== 10'd200 || lineIf.y1 !== 9'd10) begin
      errors++;
      $display("[TB] FAIL reset_coords: got %0d,%0d->%0d,%0d need 200,200->200,10",
               lineIf.x0, lineIf.y0, lineIf.x1, lineIf.y1);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_disabled_busy: got %b need 0", busy);
    end
  endtask

  task automatic test_first_draw;
    int c;
    pushLine(1'b1, 0);
    pushLine(1'b0, 0);
    pushLine(1'b1, 1);
    enable = 1'b1;
    waitBusy(1'b1, c);
    checks++;
    if (c < 0 || step !== 4'd0) begin
      errors++;
      $display("[TB] FAIL first_start: wait=%0d step=%0d need started with step 0", c, step);
    end
    waitBusy(1'b0, c);
    checks++;
    if (c !== 6) begin
      errors++;
      $display("[TB] FAIL first_line_busy: got %0d cycles need 6", c);
    end
    checks++;
    if (step !== 4'd0) begin
      errors++;
      $display("[TB] FAIL hold_step: got %0d need 0", step);
    end
    waitBusy(1'b1, c);
    checks++;
    if (c !== TICK) begin
      errors++;
      $display("[TB] FAIL hold_length: got %0d need %0d", c, TICK);
    end
    checks++;
    if (step !== 4'd1) begin
      errors++;
      $display("[TB] FAIL step_advance: got %0d need 1", step);
    end
  endtask

  task automatic test_step_advance;
    int c;
    waitBusy(1'b0, c);
    checks++;
    if (c !== 12) begin
      errors++;
      $display("[TB] FAIL pair_busy: got %0d cycles need 12", c);
    end
    checks++;
    if (expQ.size() !== 0 || step !== 4'd1) begin
      errors++;
      $display("[TB] FAIL pair_done: pending=%0d step=%0d need 0 pending step 1", expQ.size(), step);
    end
  endtask

  task automatic test_wrap;
    int c;
    int bad = 0;
    for (int k = 2; k <= 12; k++) begin
      pushLine(1'b0, k - 1);
      pushLine(1'b1, k % 12);
    end
    for (int k = 0; k < 11; k++) begin
      waitBusy(1'b1, c);
      if (c < 0) bad++;
      waitBusy(1'b0, c);
      if (c < 0) bad++;
    end
    checks++;
    if (bad !== 0 || step !== 4'd0 || expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL wrap: timeouts=%0d step=%0d pending=%0d need 0/0/0", bad, step, expQ.size());
    end
  endtask

  task automatic test_enable_park;
    int c;
    pushLine(1'b0, 0);
    pushLine(1'b1, 1);
    waitBusy(1'b1, c);
    repeat (8) @(negedge clk);
    enable = 1'b0;
    waitBusy(1'b0, c);
    checks++;
    if (c !== 4) begin
      errors++;
      $display("[TB] FAIL park_completes_line: got %0d cycles need 4", c);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || step !== 4'd1) begin
      errors++;
      $display("[TB] FAIL parked: busy=%b step=%0d need 0/1", busy, step);
    end
    pushLine(1'b0, 1);
    pushLine(1'b1, 2);
    enable = 1'b1;
    waitBusy(1'b1, c);
    checks++;
    if (c !== TICK) begin
      errors++;
      $display("[TB] FAIL resume_full_hold: got %0d need %0d", c, TICK);
    end
    waitBusy(1'b0, c);
    // Freeze three ticks into HOLD; five should remain after resuming.
    pushLine(1'b0, 2);
    pushLine(1'b1, 3);
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || step !== 4'd2) begin
      errors++;
      $display("[TB] FAIL mid_hold_freeze: busy=%b step=%0d need 0/2", busy, step);
    end
    enable = 1'b1;
    waitBusy(1'b1, c);
    checks++;
    if (c !== TICK - 3 || step !== 4'd3) begin
      errors++;
      $display("[TB] FAIL resume_remaining: got %0d cycles step %0d need %0d cycles step 3", c, step, TICK - 3);
    end
    waitBusy(1'b0, c);
  endtask

  task automatic test_spurious_done;
    int c;
    int c2;
    enable   = 1'b0;
    spurDone = 1'b1;
    repeat (6) @(negedge clk);
    spurDone = 1'b0;
    checks++;
    if (busy !== 1'b0 || step !== 4'd3 || expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL spurious_hold: busy=%b step=%0d pending=%0d need 0/3/0", busy, step, expQ.size());
    end
    pushLine(1'b0, 3);
    pushLine(1'b1, 4);
    enable = 1'b1;
    waitBusy(1'b1, c);
    checks++;
    if (c !== TICK) begin
      errors++;
      $display("[TB] FAIL spurious_hold_tick: got %0d need %0d", c, TICK);
    end
    spurDone = 1'b1;
    @(negedge clk);
    spurDone = 1'b0;
    waitBusy(1'b0, c2);
    checks++;
    if (c2 + 1 !== 12) begin
      errors++;
      $display("[TB] FAIL spurious_req: pair took %0d cycles need 12", c2 + 1);
    end
  endtask

  task automatic test_reset_mid_line;
    int c;
    pushLine(1'b0, 4);
    waitBusy(1'b1, c);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({lineIf.draw_start, lineIf.pixel_color, busy} !== 3'b000 || step !== 4'd0 ||
        lineIf.x1 !== 10'd200 || lineIf.y1 !== 9'd10) begin
      errors++;
      $display("[TB] FAIL async_reset: start/colour/busy=%b step=%0d x1=%0d y1=%0d need 000/0/200/10",
               {lineIf.draw_start, lineIf.pixel_color, busy}, step, lineIf.x1, lineIf.y1);
    end
    enable = 1'b0;
    repeat (8) @(negedge clk);
    reset    = 1'b1;
    spurDone = 1'b1;
    repeat (4) @(negedge clk);
    spurDone = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL spurious_idle: busy=%b need 0", busy);
    end
    pushLine(1'b1, 0);
    enable = 1'b1;
    waitBusy(1'b1, c);
    waitBusy(1'b0, c);
    checks++;
    if (c !== 6 || step !== 4'd0 || expQ.size() !== 0) begin
      errors++;
      $display("[TB] FAIL post_reset_draw: busy %0d cycles step %0d pending %0d need 6/0/0", c, step, expQ.size());
    end
    enable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting hand_sequencer bench");
    test_reset();
    test_first_draw();
    test_step_advance();
    test_wrap();
    test_enable_park();
    test_spurious_done();
    test_reset_mid_line();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
